// File: rtl/nand_vector_checker_if.sv
// Signal bundle between the NAND vector checker and its environment (stimulus
// control, the cell under test and the result consumer).
interface nand_vector_checker_if #(
    parameter int ERR_W = 8
);
    // start is a level request: it is accepted on any clock edge in IDLE or DONE,
    // ignored while busy, and done stays high until the next accepted start.
    logic             start;
    logic             dut_y;
    logic             dut_a;
    logic             dut_b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       first_fail_vec;
    logic             first_fail_valid;
    logic [1:0]       fsm_state;

    modport master (
        input  start, dut_y,
        output dut_a, dut_b, busy, done, pass, err_count,
               first_fail_vec, first_fail_valid, fsm_state
    );

    modport slave (
        output start, dut_y,
        input  dut_a, dut_b, busy, done, pass, err_count,
               first_fail_vec, first_fail_valid, fsm_state
    );
endinterface

// File: rtl/nand_vector_checker.sv
// Drives all four {a,b} vectors into a 2-input NAND cell, samples y after a
// programmable settle time and accumulates a saturating mismatch count.
module nand_vector_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nand_vector_checker_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // SAMPLE itself occupies one cycle, so SETTLE holds for SETTLE_CYCLES-1
    // further cycles; every vector then costs exactly SETTLE_CYCLES+1 cycles.
    localparam logic [7:0]       SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0]      LAST_PASS   = 16'(NUM_PASSES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t           state, state_nxt, entry_state;
    logic [1:0]       vec, vec_nxt, vec_inc;
    logic [15:0]      pass_cnt, pass_cnt_nxt;
    logic [7:0]       settle_cnt, settle_cnt_nxt;
    logic             a_q, a_nxt, b_q, b_nxt;
    logic             busy_q, busy_nxt, done_q, done_nxt;
    logic [ERR_W-1:0] err_q, err_nxt;
    logic [1:0]       ffv_q, ffv_nxt;
    logic             ffvalid_q, ffvalid_nxt;
    logic             exp_y, mismatch;

    assign entry_state = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
    assign vec_inc     = vec + 2'd1;
    assign exp_y       = ~(vec[1] & vec[0]);
    // Case equality so that an X or Z from the cell is scored as a mismatch.
    assign mismatch    = !(bus.dut_y === exp_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= 2'd0;
            pass_cnt   <= 16'd0;
            settle_cnt <= 8'd0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= '0;
            ffv_q      <= 2'd0;
            ffvalid_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            vec        <= vec_nxt;
            pass_cnt   <= pass_cnt_nxt;
            settle_cnt <= settle_cnt_nxt;
            a_q        <= a_nxt;
            b_q        <= b_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            err_q      <= err_nxt;
            ffv_q      <= ffv_nxt;
            ffvalid_q  <= ffvalid_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        vec_nxt        = vec;
        pass_cnt_nxt   = pass_cnt;
        settle_cnt_nxt = settle_cnt;
        a_nxt          = a_q;
        b_nxt          = b_q;
        busy_nxt       = busy_q;
        done_nxt       = done_q;
        err_nxt        = err_q;
        ffv_nxt        = ffv_q;
        ffvalid_nxt    = ffvalid_q;

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt      = entry_state;
                    vec_nxt        = 2'd0;
                    pass_cnt_nxt   = 16'd0;
                    settle_cnt_nxt = SETTLE_LOAD;
                    a_nxt          = 1'b0;
                    b_nxt          = 1'b0;
                    busy_nxt       = 1'b1;
                    done_nxt       = 1'b0;
                    err_nxt        = '0;
                    ffv_nxt        = 2'd0;
                    ffvalid_nxt    = 1'b0;
                end
            end
            SETTLE: begin
                if (settle_cnt == 8'd0) begin
                    state_nxt = SAMPLE;
                end else begin
                    settle_cnt_nxt = settle_cnt - 8'd1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_nxt = err_q + 1'b1;
                    end
                    if (!ffvalid_q) begin
                        ffv_nxt     = vec;
                        ffvalid_nxt = 1'b1;
                    end
                end
                if (vec != 2'd3 || pass_cnt != LAST_PASS) begin
                    vec_nxt        = vec_inc;
                    pass_cnt_nxt   = (vec == 2'd3) ? pass_cnt + 16'd1 : pass_cnt;
                    a_nxt          = vec_inc[1];
                    b_nxt          = vec_inc[0];
                    settle_cnt_nxt = SETTLE_LOAD;
                    state_nxt      = entry_state;
                end else begin
                    state_nxt = DONE;
                    a_nxt     = 1'b0;
                    b_nxt     = 1'b0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.dut_a            = a_q;
    assign bus.dut_b            = b_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = done_q && (err_q == '0);
    assign bus.err_count        = err_q;
    assign bus.first_fail_vec   = ffv_q;
    assign bus.first_fail_valid = ffvalid_q;
    assign bus.fsm_state        = state;

endmodule
